// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: synchronised, centre-sampling UART receiver with valid/ready output and error pulses
module uart_rx_deframer #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUDRATE  = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] shift;
  logic done;
  logic rx_s;
  logic bit_end;
  assign rx_s = sync[1];
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      done <= 1'b0;
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      frame_err <= 1'b0;
      overrun <= 1'b0;
      done <= 1'b0;
      // A completing byte may load in the same cycle the old one is taken
      if (done && valid && !ready) overrun <= 1'b1;
      else if (done) begin
        data <= shift;
        valid <= 1'b1;
      end else if (valid && ready) valid <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          cnt <= '0;
        end
        START: if (cnt == CW'(HALF_BIT - 1)) begin
          cnt <= '0;
          idx <= '0;
          state <= rx_s ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (bit_end) begin
          cnt <= '0;
          shift <= {rx_s, shift[DATA_BITS-1:1]};
          idx <= (idx == IW'(DATA_BITS - 1)) ? '0 : idx + 1'b1;
          state <= (idx == IW'(DATA_BITS - 1)) ? STOP : DATA;
        end else cnt <= cnt + 1'b1;
        STOP: if (bit_end) begin
          cnt <= '0;
          if (!rx_s) begin
            frame_err <= 1'b1;
            state <= WAIT_HIGH;
          end else if (idx == IW'(STOP_BITS - 1)) begin
            done <= 1'b1;
            state <= IDLE;
          end else idx <= idx + 1'b1;
        end else cnt <= cnt + 1'b1;
        WAIT_HIGH: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: scenario tasks checking the receiver against a byte-level model of the line
module tb_uart_rx_deframer;
  localparam int CLK_FREQ = 2_500_000;
  localparam int BAUDRATE = 115200;
  localparam int CPB = CLK_FREQ / BAUDRATE;
  localparam int HALF = CPB / 2;
  localparam int LAT = 2 + HALF + 9 * CPB;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic ready = 1'b1;
  logic [7:0] data;
  logic valid, frame_err, overrun;
  int tests = 0, failed = 0;
  int cyc = 0, fe_n = 0, ov_n = 0, vcyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic valid_q = 1'b0;
  logic [7:0] got[$];

  uart_rx_deframer #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUDRATE), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .rx(rx), .ready(ready), .data(data),
    .valid(valid), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid && ready) got.push_back(data);
    if (frame_err) fe_n <= fe_n + 1;
    if (overrun) ov_n <= ov_n + 1;
    if (valid) vcyc <= vcyc + 1;
    if (valid && !valid_q) rise_cyc <= cyc;
    valid_q <= valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    logic [9:0] f;
    f = {stop_v, b, 1'b0};
    fall_cyc = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      tick(CPB);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    tests++; if (valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b want 0", valid); end
    tests++; if (data !== 8'h00) begin failed++; $display("FAIL reset_data got %h want 00", data); end
    tests++; if ({frame_err, overrun} !== 2'b00) begin failed++; $display("FAIL reset_flags got %b want 00", {frame_err, overrun}); end
    reset = 1'b0;
    tick(5);
  endtask

  task automatic test_single;
    int n0, f0, o0, v0, d;
    n0 = got.size(); f0 = fe_n; o0 = ov_n; v0 = vcyc;
    ready = 1'b1;
    send_frame(8'hCE, 1'b1);
    tick(CPB);
    d = rise_cyc - fall_cyc;
    tests++; if (got.size() !== n0 + 1) begin failed++; $display("FAIL single_count got %0d want %0d", got.size() - n0, 1); end
    tests++; if ((got.size() > n0 ? got[n0] : 8'hxx) !== 8'hCE) begin failed++; $display("FAIL single_data got %h want ce", got.size() > n0 ? got[n0] : 8'hxx); end
    tests++; if (vcyc - v0 !== 1) begin failed++; $display("FAIL single_valid_width got %0d want 1", vcyc - v0); end
    tests++; if (d < LAT - 2 || d > LAT + 2) begin failed++; $display("FAIL single_latency got %0d want %0d+-2", d, LAT); end
    tests++; if (fe_n - f0 !== 0 || ov_n - o0 !== 0) begin failed++; $display("FAIL single_flags got fe=%0d ov=%0d want 0 0", fe_n - f0, ov_n - o0); end
  endtask

  task automatic test_back_to_back;
    int n0, f0, o0;
    n0 = got.size(); f0 = fe_n; o0 = ov_n;
    send_frame(8'h23, 1'b1);
    send_frame(8'h01, 1'b1);
    tick(CPB);
    tests++; if (got.size() !== n0 + 2) begin failed++; $display("FAIL b2b_count got %0d want 2", got.size() - n0); end
    tests++; if ((got.size() > n0 ? got[n0] : 8'hxx) !== 8'h23) begin failed++; $display("FAIL b2b_first got %h want 23", got.size() > n0 ? got[n0] : 8'hxx); end
    tests++; if ((got.size() > n0 + 1 ? got[n0+1] : 8'hxx) !== 8'h01) begin failed++; $display("FAIL b2b_second got %h want 01", got.size() > n0 + 1 ? got[n0+1] : 8'hxx); end
    tests++; if (fe_n - f0 !== 0 || ov_n - o0 !== 0) begin failed++; $display("FAIL b2b_flags got fe=%0d ov=%0d want 0 0", fe_n - f0, ov_n - o0); end
  endtask

  task automatic test_glitch;
    int n0, f0;
    n0 = got.size(); f0 = fe_n;
    rx = 1'b0;
    tick(HALF / 2);
    rx = 1'b1;
    tick(2 * CPB);
    tests++; if (got.size() !== n0 || fe_n !== f0) begin failed++; $display("FAIL glitch_quiet got bytes=%0d fe=%0d want 0 0", got.size() - n0, fe_n - f0); end
    send_frame(8'h5A, 1'b1);
    tick(CPB);
    tests++; if ((got.size() == n0 + 1 ? got[n0] : 8'hxx) !== 8'h5A) begin failed++; $display("FAIL glitch_after got %h want 5a", got.size() > n0 ? got[n0] : 8'hxx); end
  endtask

  task automatic test_break;
    int n0, f0;
    n0 = got.size(); f0 = fe_n;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    tick(3 * CPB);
    rx = 1'b1;
    tick(CPB);
    tests++; if (fe_n - f0 !== 1) begin failed++; $display("FAIL break_fe got %0d want 1", fe_n - f0); end
    tests++; if (got.size() !== n0) begin failed++; $display("FAIL break_novalid got %0d want 0", got.size() - n0); end
    send_frame(8'hA5, 1'b1);
    tick(CPB);
    tests++; if ((got.size() == n0 + 1 ? got[n0] : 8'hxx) !== 8'hA5) begin failed++; $display("FAIL break_after got %h want a5", got.size() > n0 ? got[n0] : 8'hxx); end
  endtask

  task automatic test_overrun;
    int n0, o0;
    n0 = got.size(); o0 = ov_n;
    ready = 1'b0;
    send_frame(8'h01, 1'b1);
    tick(CPB);
    tests++; if ({valid, data} !== {1'b1, 8'h01}) begin failed++; $display("FAIL ovr_hold got valid=%b data=%h want 1 01", valid, data); end
    send_frame(8'h02, 1'b1);
    tick(CPB);
    tests++; if (ov_n - o0 !== 1) begin failed++; $display("FAIL ovr_pulse got %0d want 1", ov_n - o0); end
    tests++; if ({valid, data} !== {1'b1, 8'h01}) begin failed++; $display("FAIL ovr_keep got valid=%b data=%h want 1 01", valid, data); end
    ready = 1'b1;
    tick(3);
    tests++; if (got.size() !== n0 + 1 || got[got.size()-1] !== 8'h01) begin failed++; $display("FAIL ovr_drain got count=%0d want 1 byte 01", got.size() - n0); end
    tests++; if (valid !== 1'b0) begin failed++; $display("FAIL ovr_empty got valid=%b want 0", valid); end
  endtask

  task automatic test_reset_mid;
    int n0, f0;
    n0 = got.size(); f0 = fe_n;
    fall_cyc = cyc + 1;
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB + HALF);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tests++; if ({valid, data, frame_err, overrun} !== 11'd0) begin failed++; $display("FAIL rstmid_outputs got valid=%b data=%h fe=%b ov=%b want all 0", valid, data, frame_err, overrun); end
    tick(6 * CPB);
    tests++; if (got.size() !== n0 || fe_n !== f0) begin failed++; $display("FAIL rstmid_quiet got bytes=%0d fe=%0d want 0 0", got.size() - n0, fe_n - f0); end
    send_frame(8'h3C, 1'b1);
    tick(CPB);
    tests++; if ((got.size() == n0 + 1 ? got[n0] : 8'hxx) !== 8'h3C) begin failed++; $display("FAIL rstmid_after got %h want 3c", got.size() > n0 ? got[n0] : 8'hxx); end
  endtask

  task automatic test_random;
    logic [7:0] exp[$];
    logic [7:0] b;
    int n0, f0, o0;
    n0 = got.size(); f0 = fe_n; o0 = ov_n;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      exp.push_back(b);
      send_frame(b, 1'b1);
      tick($urandom_range(0, CPB));
    end
    tick(CPB);
    tests++; if (got.size() - n0 !== exp.size()) begin failed++; $display("FAIL rand_count got %0d want %0d", got.size() - n0, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      tests++; if ((got.size() > n0 + i ? got[n0+i] : 8'hxx) !== exp[i]) begin failed++; $display("FAIL rand_byte%0d got %h want %h", i, got.size() > n0 + i ? got[n0+i] : 8'hxx, exp[i]); end
    end
    tests++; if (fe_n - f0 !== 0 || ov_n - o0 !== 0) begin failed++; $display("FAIL rand_flags got fe=%0d ov=%0d want 0 0", fe_n - f0, ov_n - o0); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_break;
    test_overrun;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
